mvm_act_pack: RTL and testbench
===============================

# mvm_act_pack

Downstream stage of the matrix-vector multiplier. Consumes the stream of signed 16-bit dot-product results together with the multiplier's overflow flag, and applies ReLU, rounding right-shift requantization and 8-bit saturation to each result. It collects NROWS results into one output vector in a two-bank ping-pong buffer, then streams the vector out as signed 8-bit activations, ready to be loaded as the vector operand of the next layer.

## Interface
- NROWS, 3: results per vector, ≥2.
- SHIFT, 4: requantization right-shift amount, 0..8.
- RELU_EN, 1: 1 clamps negative results to 0; 0 passes them through.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  one clock; synchronous, active-low reset.
- s_valid  in  1  upstream result valid.
- s_ready  out  1  block can accept a result.
- data_in  in  16  signed result from the multiplier.
- ovf_in  in  1  multiplier overflow, qualified with s_valid.
- m_valid  out  1  output activation valid.
- m_ready  in  1  downstream accepts.
- data_out  out  8  signed activation.
- m_last  out  1  high on the final element (index NROWS-1) of each vector.
- ovf_out  out  1  vector-level flag, held constant on every beat of a vector.

## Operation
- Two banks, each holding NROWS 8-bit entries, a full bit and a flag bit. A write-bank pointer and a write index select the target entry. A read-bank pointer and a read index select the output entry.
- Input accept happens when s_valid && s_ready. The accepted value is processed as follows:
  - r = (RELU_EN && data_in<0) ? 0 : data_in.
  - t = r + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed in 17 bits signed so it cannot wrap.
  - q = t >>> SHIFT (arithmetic shift).
  - out = saturate(q) to [-128,127].
- Saturation event: q outside [-128,127]. The write bank's flag ORs in (ovf_in | saturation event).
- On accept, the entry is stored at the write index and the index increments. When index NROWS-1 is accepted:
  - bank full ← 1;
  - index ← 0;
  - write-bank pointer toggles.
- s_ready = !full[write bank]. It depends only on registers, never on s_valid.
- m_valid = full[read bank]. The outputs come straight from the read-bank registers:
  - data_out = entry[read index];
  - m_last = (read index == NROWS-1);
  - ovf_out = flag[read bank].
- Output accept happens when m_valid && m_ready, and the read index increments. On the m_last accept:
  - full ← 0;
  - flag ← 0;
  - read index ← 0;
  - read-bank pointer toggles.
- Simultaneous input fill of one bank and output free of the other in the same cycle: both take effect; there is no interaction.
- Both banks full: s_ready=0, input stalls, and data_in/ovf_in are ignored.
- Counters wrap only as specified (NROWS-1 → 0). No other wrap is allowed.
- Reset (reset_n=0, including mid-vector): clears full bits, flags, indices and both pointers. Any partial vector is discarded. Bank contents need not be cleared, but data_out must read 0 after reset.

## Timing
- Reset values: s_ready=1 in the first cycle after reset release; m_valid=0, data_out=0, m_last=0, ovf_out=0.
- Latency: the last element of a vector is accepted at edge t. m_valid=1 with element 0 on data_out in the cycle after edge t.
- Throughput: one beat per cycle on each side. With m_ready held high, s_ready never deasserts and vectors stream back-to-back.
- Handshake rules:
  - With m_valid=1 and m_ready=0, data_out, m_last and ovf_out stay stable until accepted.
  - m_valid never drops without an accept, except on reset.
- Worst-case stall: both banks full. s_ready returns to 1 in the cycle after the m_last accept.

## Test plan
- Requantization, NROWS=3, SHIFT=4, RELU_EN=1. Input 100, -100, 5000 with ovf_in=0 → outputs 6, 0, 127 with m_last on the third beat, and ovf_out=1 on all three beats (5000 saturates).
- Rounding and RELU_EN=0, SHIFT=4. Input -24, 7, 8 → outputs -1, 0, 1. Input -32768 → -128 with ovf_out=1. Input 32767 → 127 with ovf_out=1.
- Overflow propagation. Vector 16, 32, 48 with ovf_in=1 on beat 2 only → 1, 2, 3 with ovf_out=1. The next vector, with all ovf_in=0, → ovf_out=0.
- Backpressure, m_ready=0. Feed 2 vectors (6 beats) → s_ready=0 from the cycle after the 6th accept, and a 7th s_valid is not accepted. Raise m_ready → both vectors drain in order. s_ready=1 in the cycle after the first m_last accept, and the 7th beat is then accepted.
- Streaming, m_ready=1 and s_valid=1 continuously for 10 vectors → s_ready stays 1 throughout. The first m_valid appears 1 cycle after the 3rd accept, and the outputs match the reference model in order.
- Reset mid-vector. Accept 2 beats, pulse reset_n low for 1 cycle → m_valid=0 and s_ready=1 after release. The next 3 beats form a complete vector with no residue from the discarded beats.

Source files
------------

// File: rtl/mvm_act_pack.sv
// Activation pack stage: ReLU, rounding requantization and int8 saturation of
// matrix-vector results, collected per vector in a ping-pong buffer and streamed out.
module mvm_act_pack #(
  parameter int NROWS   = 3,
  parameter int SHIFT   = 4,
  parameter bit RELU_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] data_in,
  input  logic        ovf_in,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  data_out,
  output logic        m_last,
  output logic        ovf_out
);

  localparam int IDX_W = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NROWS - 1);
  localparam logic signed [16:0] RND = (SHIFT > 0) ? 17'(1 << (SHIFT - 1)) : 17'sd0;

  // ReLU, add half an LSB and shift; 17 bits so the rounding add cannot wrap
  function automatic logic signed [16:0] requant(input logic signed [15:0] d);
    logic signed [15:0] r;
    logic signed [16:0] t;
    r = (RELU_EN && (d < 16'sd0)) ? 16'sd0 : d;
    t = $signed({r[15], r}) + RND;
    return t >>> SHIFT;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [16:0] q);
    if (q > 17'sd127)
      return 8'sd127;
    else if (q < -17'sd128)
      return -8'sd128;
    return q[7:0];
  endfunction

  function automatic logic sat_hit(input logic signed [16:0] q);
    return (q > 17'sd127) || (q < -17'sd128);
  endfunction

  logic signed [7:0]  bank_mem [2][NROWS];
  logic [1:0]         full;
  logic [1:0]         flag;
  logic               wr_bank;
  logic               rd_bank;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;

  logic signed [16:0] q_p0;
  logic signed [7:0]  act_p0;
  logic               sat_p0;
  logic               in_acc;
  logic               out_acc;

  assign q_p0   = requant($signed(data_in));
  assign act_p0 = sat8(q_p0);
  assign sat_p0 = sat_hit(q_p0);

  assign s_ready = !full[wr_bank];
  assign m_valid = full[rd_bank];
  assign in_acc  = s_valid && s_ready;
  assign out_acc = m_valid && m_ready;

  // Bank storage is data only and never reset; data_out is masked until a vector is ready
  always_ff @(posedge clk) begin
    if (in_acc)
      bank_mem[wr_bank][wr_idx] <= act_p0;
  end

  assign data_out = m_valid ? bank_mem[rd_bank][rd_idx] : 8'd0;
  assign m_last   = (rd_idx == LAST_IDX);
  assign ovf_out  = flag[rd_bank];

  // Fill and drain always target different banks, so their updates never collide
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full    <= 2'b00;
      flag    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
    end else begin
      if (in_acc) begin
        flag[wr_bank] <= flag[wr_bank] | ovf_in | sat_p0;
        if (wr_idx == LAST_IDX) begin
          full[wr_bank] <= 1'b1;
          wr_idx        <= '0;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (out_acc) begin
        if (rd_idx == LAST_IDX) begin
          full[rd_bank] <= 1'b0;
          flag[rd_bank] <= 1'b0;
          rd_idx        <= '0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mvm_act_pack.sv
// Directed bench for mvm_act_pack: two instances (ReLU on / off) share all inputs.
module tb_mvm_act_pack;

  logic        clk = 1'b0;
  logic        reset_n, s_valid, ovf_in, m_ready;
  logic [15:0] data_in;
  logic        a_s_ready, a_m_valid, a_m_last, a_ovf_out;
  logic [7:0]  a_data_out;
  logic        b_s_ready, b_m_valid, b_m_last, b_ovf_out;
  logic [7:0]  b_data_out;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  mvm_act_pack #(.NROWS(3), .SHIFT(4), .RELU_EN(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(a_s_ready),
    .data_in(data_in), .ovf_in(ovf_in), .m_valid(a_m_valid), .m_ready(m_ready),
    .data_out(a_data_out), .m_last(a_m_last), .ovf_out(a_ovf_out));

  mvm_act_pack #(.NROWS(3), .SHIFT(4), .RELU_EN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(b_s_ready),
    .data_in(data_in), .ovf_in(ovf_in), .m_valid(b_m_valid), .m_ready(m_ready),
    .data_out(b_data_out), .m_last(b_m_last), .ovf_out(b_ovf_out));

  typedef struct packed {
    logic [2:0][15:0] d;
    logic [2:0]       ovf;
    logic [2:0][7:0]  ea;
    logic [2:0][7:0]  eb;
    logic             fa;
    logic             fb;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int d0, input int d1, input int d2, input logic [2:0] ov,
                              input int a0, input int a1, input int a2,
                              input int b0, input int b1, input int b2,
                              input logic fa, input logic fb);
    vec_t v;
    v.d[0] = 16'(d0); v.d[1] = 16'(d1); v.d[2] = 16'(d2);
    v.ovf = ov;
    v.ea[0] = 8'(a0); v.ea[1] = 8'(a1); v.ea[2] = 8'(a2);
    v.eb[0] = 8'(b0); v.eb[1] = 8'(b1); v.eb[2] = 8'(b2);
    v.fa = fa; v.fb = fb;
    return v;
  endfunction

  // Independent reference: floor division of (r + 8) by 16, then clamp
  function automatic void model(input int d, input bit relu, output int q, output bit sat);
    int r, t, f;
    r = (relu && d < 0) ? 0 : d;
    t = r + 8;
    f = (t >= 0) ? t / 16 : -((-t + 15) / 16);
    sat = (f > 127) || (f < -128);
    q = (f > 127) ? 127 : (f < -128) ? -128 : f;
  endfunction

  task automatic send_beat(input int d, input bit ov);
    int n;
    n = 0;
    s_valid = 1'b1;
    data_in = 16'(d);
    ovf_in  = ov;
    @(negedge clk);
    while (!a_s_ready && n < 200) begin
      stall_cnt++;
      n++;
      @(negedge clk);
    end
    if (!a_s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready stayed 0 for data %0d", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic recv_beat(input int ea, input int eb, input bit last, input bit fa, input bit fb);
    int n;
    n = 0;
    m_ready = 1'b1;
    @(negedge clk);
    while (!a_m_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!a_m_valid) begin
      checks++;
      errors++;
      $display("FAIL recv_timeout: m_valid stayed 0, expected data %0d", ea);
    end else begin
      chk("data_relu", int'($signed(a_data_out)), ea);
      chk("data_norelu", int'($signed(b_data_out)), eb);
      chk("m_last", int'(a_m_last), int'(last));
      chk("ovf_relu", int'(a_ovf_out), int'(fa));
      chk("ovf_norelu", int'(b_ovf_out), int'(fb));
      chk("m_valid_norelu", int'(b_m_valid), 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic recv_vec(input vec_t v);
    for (int i = 0; i < 3; i++)
      recv_beat(int'($signed(v.ea[i])), int'($signed(v.eb[i])), i == 2, v.fa, v.fb);
  endtask

  task automatic send_vec(input vec_t v);
    for (int i = 0; i < 3; i++)
      send_beat(int'($signed(v.d[i])), v.ovf[i]);
    s_valid = 1'b0;
  endtask

  int   sd [30];
  bit   sov [30];
  int   sea [30];
  int   seb [30];
  bit   sfa [10];
  bit   sfb [10];

  initial begin
    tbl[0] = mk(100, -100, 5000, 3'b000, 6, 0, 127, 6, -6, 127, 1'b1, 1'b1);
    tbl[1] = mk(-24, 7, 8, 3'b000, 0, 0, 1, -1, 0, 1, 1'b0, 1'b0);
    tbl[2] = mk(-32768, 32767, 16, 3'b000, 0, 127, 1, -128, 127, 1, 1'b1, 1'b1);
    tbl[3] = mk(0, 0, -32768, 3'b000, 0, 0, 0, 0, 0, -128, 1'b0, 1'b1);
    tbl[4] = mk(16, 32, 48, 3'b010, 1, 2, 3, 1, 2, 3, 1'b1, 1'b1);
    tbl[5] = mk(16, 32, 48, 3'b000, 1, 2, 3, 1, 2, 3, 1'b0, 1'b0);
    tbl[6] = mk(2039, -2056, 0, 3'b000, 127, 0, 0, 127, -128, 0, 1'b0, 1'b0);
    tbl[7] = mk(2040, 0, 0, 3'b000, 127, 0, 0, 127, 0, 0, 1'b1, 1'b1);
    tbl[8] = mk(-2057, 0, 0, 3'b000, 0, 0, 0, -128, 0, 0, 1'b0, 1'b1);

    reset_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = 16'd0;
    ovf_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", int'(a_s_ready), 1);
    chk("rst_m_valid", int'(a_m_valid), 0);
    chk("rst_data_out", int'(a_data_out), 0);
    chk("rst_m_last", int'(a_m_last), 0);
    chk("rst_ovf_out", int'(a_ovf_out), 0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 9; v++) begin
      send_vec(tbl[v]);
      recv_vec(tbl[v]);
      m_ready = 1'b0;
    end

    // Backpressure: two full banks stall the input
    m_ready = 1'b0;
    send_vec(tbl[0]);
    send_vec(tbl[4]);
    s_valid = 1'b1;
    data_in = 16'd160;
    ovf_in  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_s_ready_low", int'(a_s_ready), 0);
      chk("bp_m_valid_held", int'(a_m_valid), 1);
      chk("bp_data_stable", int'($signed(a_data_out)), 6);
      chk("bp_ovf_stable", int'(a_ovf_out), 1);
    end
    @(posedge clk);
    #1;
    recv_vec(tbl[0]);
    m_ready = 1'b0;
    @(negedge clk);
    chk("bp_s_ready_back", int'(a_s_ready), 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("bp_next_head", int'($signed(a_data_out)), 1);
    recv_vec(tbl[4]);
    m_ready = 1'b0;
    send_beat(176, 1'b0);
    send_beat(192, 1'b0);
    s_valid = 1'b0;
    recv_beat(10, 10, 1'b0, 1'b0, 1'b0);
    recv_beat(11, 11, 1'b0, 1'b0, 1'b0);
    recv_beat(12, 12, 1'b1, 1'b0, 1'b0);

    // Streaming: 10 back-to-back vectors
    for (int k = 0; k < 30; k++) begin
      int q;
      bit s;
      sd[k]  = ((k * 5471) % 65536) - 32768;
      sov[k] = (k % 7) == 3;
      if (k % 3 == 0) begin
        sfa[k / 3] = 1'b0;
        sfb[k / 3] = 1'b0;
      end
      model(sd[k], 1'b1, q, s);
      sea[k] = q;
      sfa[k / 3] = sfa[k / 3] | s | sov[k];
      model(sd[k], 1'b0, q, s);
      seb[k] = q;
      sfb[k / 3] = sfb[k / 3] | s | sov[k];
    end
    stall_cnt = 0;
    m_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          send_beat(sd[k], sov[k]);
          if (k == 1) chk("lat_m_valid_before", int'(a_m_valid), 0);
          if (k == 2) chk("lat_m_valid_after", int'(a_m_valid), 1);
        end
        s_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 30; k++)
          recv_beat(sea[k], seb[k], (k % 3) == 2, sfa[k / 3], sfb[k / 3]);
      end
    join
    chk("stream_no_stall", stall_cnt, 0);
    m_ready = 1'b0;

    // Reset mid-vector discards the partial vector and its flag
    send_beat(500, 1'b1);
    send_beat(600, 1'b0);
    s_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_s_ready", int'(a_s_ready), 1);
    chk("mid_rst_m_valid", int'(a_m_valid), 0);
    chk("mid_rst_data_out", int'(a_data_out), 0);
    chk("mid_rst_ovf_out", int'(a_ovf_out), 0);
    @(posedge clk);
    #1;
    send_vec(tbl[1]);
    recv_vec(tbl[1]);
    m_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
